// File: rtl/pwm_gen_pkg.sv
// Shared constants for the PWM board: 7-seg patterns, digit count, select idle.
`timescale 1ns/1ps
package pwm_gen_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [5:0] SEL_IDLE = 6'b111111;

  // {dp,g,f,e,d,c,b,a}, active-low
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_decode(
    input logic [3:0] d
  );
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/pwm_generator_top_tick_prescaler.sv
// Free-running P-bit counter; tick is high while the count is all-ones.
`timescale 1ns/1ps
module tick_prescaler #(
  parameter int P = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [P-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  assign tick = &cnt;

endmodule

// File: rtl/pwm_generator_top.sv
// PWM board top: button-set duty, ramp compare, 3-digit scanned readout.
// Define BRAKE_EN to short both H-bridge inputs high at zero duty.
`timescale 1ns/1ps
module pwm_generator_top
  import pwm_gen_pkg::*;
#(
  parameter int FRECUENCY_BITS  = 3,
  parameter int RESOLUTION_BITS = 8,
  parameter int CONT_SPEED      = 4,
  parameter int SCAN_SPEED      = 3
) (
  input  logic                       clk_top,
  input  logic                       rst_top,
  input  logic                       sum_top,
  input  logic                       rest_top,
  output logic                       enaGen,
  output logic                       enaSel,
  output logic                       enaSca,
  output logic                       pwm_top,
  output logic                       rdy_top,
  output logic [RESOLUTION_BITS-1:0] valorReference,
  output logic [RESOLUTION_BITS-1:0] valueGenerator,
  output logic [3:0]                 fdig_top,
  output logic [3:0]                 sdig_top,
  output logic [3:0]                 tdig_top,
  output logic [7:0]                 seg_data1,
  output logic [7:0]                 seg_data2,
  output logic [7:0]                 seg_data3,
  output logic [5:0]                 seg_sel_top,
  output logic [7:0]                 seg_data_top,
  output logic                       in1_top,
  output logic                       in2_top
);

  localparam int RES = RESOLUTION_BITS;
  localparam logic [RES-1:0] REF_MAX = '1;
  localparam logic [RES-1:0] REF_MID =
    {1'b1, {(RES-1){1'b0}}};

  tick_prescaler #(.P(FRECUENCY_BITS)) u_gen (
    .clk   (clk_top),
    .rst_n (rst_top),
    .tick  (enaGen)
  );

  tick_prescaler #(.P(CONT_SPEED)) u_sel (
    .clk   (clk_top),
    .rst_n (rst_top),
    .tick  (enaSel)
  );

  tick_prescaler #(.P(SCAN_SPEED)) u_sca (
    .clk   (clk_top),
    .rst_n (rst_top),
    .tick  (enaSca)
  );

  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      valueGenerator <= '0;
      rdy_top        <= 1'b0;
      pwm_top        <= 1'b0;
    end else begin
      rdy_top <= enaGen && (valueGenerator == REF_MAX);
      pwm_top <= valueGenerator < valorReference;
      if (enaGen) valueGenerator <= valueGenerator + 1'b1;
    end
  end

  logic inc_ok;
  logic dec_ok;

  // Saturation is folded into the request so the case stays one-hot
  assign inc_ok = !sum_top && rest_top &&
                  (valorReference != REF_MAX);
  assign dec_ok = !rest_top && sum_top &&
                  (valorReference != '0);

  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      valorReference <= REF_MID;
    end else if (enaSel) begin
      unique case (1'b1)
        inc_ok:  valorReference <= valorReference + 1'b1;
        dec_ok:  valorReference <= valorReference - 1'b1;
        default: ;
      endcase
    end
  end

  logic [9:0] ref_w;

  assign ref_w    = 10'(valorReference);
  assign fdig_top = 4'(ref_w / 10'd100);
  assign sdig_top = 4'((ref_w % 10'd100) / 10'd10);
  assign tdig_top = 4'(ref_w % 10'd10);

  assign seg_data1 = seg_decode(fdig_top);
  assign seg_data2 = seg_decode(sdig_top);
  assign seg_data3 = seg_decode(tdig_top);

  logic [1:0] scan_idx;

  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      scan_idx <= 2'd0;
    end else if (enaSca) begin
      if (scan_idx == 2'(NUM_DIGITS - 1))
        scan_idx <= 2'd0;
      else
        scan_idx <= scan_idx + 2'd1;
    end
  end

  always_comb begin
    seg_sel_top           = SEL_IDLE;
    seg_sel_top[scan_idx] = 1'b0;
  end

  always_comb begin
    seg_data_top = seg_data3;
    case (scan_idx)
      2'd0:    seg_data_top = seg_data1;
      2'd1:    seg_data_top = seg_data2;
      default: seg_data_top = seg_data3;
    endcase
  end

`ifdef BRAKE_EN
  logic brake;

  assign brake   = (valorReference == '0);
  assign in1_top = brake ? 1'b1 : pwm_top;
  assign in2_top = brake;
`else
  assign in1_top = pwm_top;
  assign in2_top = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_generator_top.sv
// Directed bench for pwm_generator_top with default parameters.
`timescale 1ns/1ps
module tb_pwm_generator_top;

  logic       clk_top = 1'b0;
  logic       rst_top;
  logic       sum_top;
  logic       rest_top;
  logic       enaGen;
  logic       enaSel;
  logic       enaSca;
  logic       pwm_top;
  logic       rdy_top;
  logic [7:0] valorReference;
  logic [7:0] valueGenerator;
  logic [3:0] fdig_top;
  logic [3:0] sdig_top;
  logic [3:0] tdig_top;
  logic [7:0] seg_data1;
  logic [7:0] seg_data2;
  logic [7:0] seg_data3;
  logic [5:0] seg_sel_top;
  logic [7:0] seg_data_top;
  logic       in1_top;
  logic       in2_top;

  int checks = 0;
  int errors = 0;

  pwm_generator_top dut (
    .clk_top        (clk_top),
    .rst_top        (rst_top),
    .sum_top        (sum_top),
    .rest_top       (rest_top),
    .enaGen         (enaGen),
    .enaSel         (enaSel),
    .enaSca         (enaSca),
    .pwm_top        (pwm_top),
    .rdy_top        (rdy_top),
    .valorReference (valorReference),
    .valueGenerator (valueGenerator),
    .fdig_top       (fdig_top),
    .sdig_top       (sdig_top),
    .tdig_top       (tdig_top),
    .seg_data1      (seg_data1),
    .seg_data2      (seg_data2),
    .seg_data3      (seg_data3),
    .seg_sel_top    (seg_sel_top),
    .seg_data_top   (seg_data_top),
    .in1_top        (in1_top),
    .in2_top        (in2_top)
  );

  always #1 clk_top = ~clk_top;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_top);
  endtask

  task automatic window(
    input  int n,
    output int ph,
    output int rd,
    output int eg,
    output int es
  );
    ph = 0; rd = 0; eg = 0; es = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_top);
      if (pwm_top === 1'b1) ph++;
      if (rdy_top === 1'b1) rd++;
      if (enaGen  === 1'b1) eg++;
      if (enaSel  === 1'b1) es++;
    end
  endtask

  initial begin
    int ph, rd, eg, es;
    rst_top  = 1'b1;
    sum_top  = 1'b1;
    rest_top = 1'b1;
    #0.2 rst_top = 1'b0;
    #1   rst_top = 1'b1;
    @(negedge clk_top);

    chk("rst_ref",  32'(valorReference), 32'd128);
    chk("rst_gen",  32'(valueGenerator), 32'd0);
    chk("rst_pwm",  32'(pwm_top), 32'd0);
    chk("rst_rdy",  32'(rdy_top), 32'd0);
    chk("rst_tick", 32'({enaGen, enaSel, enaSca}), 32'd0);
    chk("rst_dig",
        32'({fdig_top, sdig_top, tdig_top}), 32'h128);
    chk("rst_sel",  32'(seg_sel_top), 32'h3E);
    chk("rst_seg1", 32'(seg_data1), 32'hF9);
    chk("rst_seg2", 32'(seg_data2), 32'hA4);
    chk("rst_seg3", 32'(seg_data3), 32'h80);
    chk("rst_segt", 32'(seg_data_top), 32'hF9);
    chk("rst_mot",  32'({in1_top, in2_top}), 32'd0);

    step(7);
    chk("tick7_gen", 32'(enaGen), 32'd1);
    chk("tick7_sca", 32'(enaSca), 32'd1);
    chk("tick7_sel", 32'(enaSel), 32'd0);
    chk("tick7_vg",  32'(valueGenerator), 32'd0);
    step(1);
    chk("tick8_gen", 32'(enaGen), 32'd0);
    chk("tick8_vg",  32'(valueGenerator), 32'd1);
    chk("tick8_sel", 32'(seg_sel_top), 32'h3D);

    window(2048, ph, rd, eg, es);
    chk("idle_high", 32'(ph), 32'd1024);
    chk("idle_rdy",  32'(rd), 32'd1);
    chk("idle_gen",  32'(eg), 32'd256);
    chk("idle_sel",  32'(es), 32'd128);

    step(2039);
    chk("wrap_vg",  32'(valueGenerator), 32'd255);
    chk("wrap_rdy0", 32'(rdy_top), 32'd0);
    step(1);
    chk("wrap_rdy1", 32'(rdy_top), 32'd1);
    chk("wrap_vg0",  32'(valueGenerator), 32'd0);

    chk("scan2_sel", 32'(seg_sel_top), 32'h3B);
    chk("scan2_dat", 32'(seg_data_top), 32'h80);
    step(8);
    chk("scan0_sel", 32'(seg_sel_top), 32'h3E);
    chk("scan0_dat", 32'(seg_data_top), 32'hF9);
    step(8);
    chk("scan1_sel", 32'(seg_sel_top), 32'h3D);
    chk("scan1_dat", 32'(seg_data_top), 32'hA4);

    rest_top = 1'b0;
    step(500);
    rest_top = 1'b1;
    chk("dec_ref", 32'(valorReference), 32'd97);
    chk("dec_dig",
        32'({fdig_top, sdig_top, tdig_top}), 32'h097);
    chk("dec_seg",
        32'({seg_data1, seg_data2, seg_data3}),
        32'hC090F8);

    sum_top = 1'b0;
    step(50);
    sum_top = 1'b1;
    chk("inc_ref", 32'(valorReference), 32'd100);
    chk("inc_dig",
        32'({fdig_top, sdig_top, tdig_top}), 32'h100);

    sum_top  = 1'b0;
    rest_top = 1'b0;
    step(50);
    sum_top  = 1'b1;
    rest_top = 1'b1;
    chk("both_ref", 32'(valorReference), 32'd100);
    chk("both_vg",  32'(valueGenerator), 32'd77);
    chk("both_pwm", 32'(pwm_top), 32'd1);
    chk("both_mot", 32'({in1_top, in2_top}), 32'b10);

    rest_top = 1'b0;
    step(2000);
    chk("sat0_ref", 32'(valorReference), 32'd0);
    chk("sat0_dig",
        32'({fdig_top, sdig_top, tdig_top}), 32'h000);
    window(2048, ph, rd, eg, es);
    chk("sat0_high", 32'(ph), 32'd0);
    chk("sat0_hold", 32'(valorReference), 32'd0);
`ifdef BRAKE_EN
    chk("sat0_mot", 32'({in1_top, in2_top}), 32'b11);
`else
    chk("sat0_mot", 32'({in1_top, in2_top}), 32'b00);
`endif
    rest_top = 1'b1;

    sum_top = 1'b0;
    step(4200);
    chk("sat255_ref", 32'(valorReference), 32'd255);
    chk("sat255_seg",
        32'({seg_data1, seg_data2, seg_data3}),
        32'hA49292);
    window(2048, ph, rd, eg, es);
    chk("sat255_high", 32'(ph), 32'd2040);
    chk("sat255_rdy",  32'(rd), 32'd1);
    chk("sat255_hold", 32'(valorReference), 32'd255);
    sum_top = 1'b1;

    step(37);
    #0.5 rst_top = 1'b0;
    #0.1;
    chk("mid_ref", 32'(valorReference), 32'd128);
    chk("mid_vg",  32'(valueGenerator), 32'd0);
    chk("mid_pwm", 32'(pwm_top), 32'd0);
    chk("mid_sel", 32'(seg_sel_top), 32'h3E);
    chk("mid_tick",
        32'({enaGen, enaSel, enaSca}), 32'd0);
    #0.9 rst_top = 1'b1;
    @(negedge clk_top);
    chk("post_ref", 32'(valorReference), 32'd128);
    chk("post_vg",  32'(valueGenerator), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
